// File: rtl/mac8_pkg.sv
// Shared types and widths for the 8-bit multiply-accumulate dot-product stage.
package mac8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac8_dot_accumulator_if.sv
// Operand-in / result-out handshake bundle for mac8_dot_accumulator.
interface mac8_dot_accumulator_if #(
  parameter int ACC_W = 24
);
  import mac8_pkg::*;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             ovf;

  modport master (
    output start, in_valid, a, b, out_ready,
    input  in_ready, busy, out_valid, result, ovf
  );

  modport slave (
    input  start, in_valid, a, b, out_ready,
    output in_ready, busy, out_valid, result, ovf
  );

endinterface

// File: rtl/mult_8x8.sv
// Combinational unsigned 8x8 -> 16-bit multiplier.
module mult_8x8 (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] out
);

  assign out = A * B;

endmodule

// File: rtl/mac8_dot_accumulator.sv
// Accumulates N_TERMS unsigned 8x8 products into one ACC_W-bit dot product,
// with registered operands feeding mult_8x8 and a sticky carry-out flag.
module mac8_dot_accumulator
  import mac8_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mac8_dot_accumulator_if.slave   bus
);

  localparam logic [7:0] CNT_LAST = 8'(N_TERMS - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic [OP_W-1:0]   op_a, op_b;
  logic              op_vld;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    sum;
  logic              ovf;
  logic              accept;
  logic              clear;

  mult_8x8 u_mult (
    .A   (op_a),
    .B   (op_b),
    .out (product)
  );

  assign accept = bus.in_valid && (state == ACCUM);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          clear     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (cnt == CNT_LAST)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if (bus.out_ready) begin
          clear     = bus.start;
          state_nxt = bus.start ? ACCUM : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_vld <= accept;
      if (clear) begin
        cnt <= '0;
      end else if (accept) begin
        cnt  <= cnt + 8'd1;
        op_a <= bus.a;
        op_b <= bus.b;
      end
    end
  end

  // One extra bit catches the carry out of the accumulator.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (op_vld) begin
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = acc;
  assign bus.ovf       = ovf;

endmodule

// File: tb/tb_mac8_dot_accumulator.sv
// Directed-vector bench for mac8_dot_accumulator: reset, streaming, stalls,
// overflow wrap, mid-operation reset and back-to-back restart from DONE.
module tb_mac8_dot_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac8_dot_accumulator_if #(.ACC_W(24)) m ();
  mac8_dot_accumulator_if #(.ACC_W(16)) w ();

  mac8_dot_accumulator #(.N_TERMS(4), .ACC_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  mac8_dot_accumulator #(.N_TERMS(2), .ACC_W(16)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    m.start = 1'b1;
    step();
    m.start = 1'b0;
  endtask

  // Offers one pair and returns one time step after the accepting edge.
  task automatic send_pair(input logic [7:0] pa, input logic [7:0] pb);
    int n = 0;
    m.in_valid = 1'b1;
    m.a = pa;
    m.b = pb;
    @(negedge clk);
    while (!m.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (m.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_pair_timeout in_ready=%b required 1", m.in_ready);
    end
    step();
    m.in_valid = 1'b0;
  endtask

  // Waits (bounded) at negedges for out_valid; counts the wait as a comparison.
  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!m.out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (m.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout out_valid=%b required 1", tag, m.out_valid);
    end
  endtask

  task automatic release_result();
    m.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    m.start = 0; m.in_valid = 0; m.a = 0; m.b = 0; m.out_ready = 0;
    w.start = 0; w.in_valid = 0; w.a = 0; w.b = 0; w.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks += 5;
    if (m.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", m.in_ready); end
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", m.out_valid); end
    if (m.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", m.busy); end
    if (m.result !== 24'd0) begin errors++; $display("FAIL rst_result got %0d want 0", m.result); end
    if (m.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", m.ovf); end
    // A pair offered while IDLE must not be consumed.
    m.in_valid = 1'b1; m.a = 8'd9; m.b = 8'd9;
    repeat (2) begin
      @(negedge clk);
      checks += 2;
      if (m.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b want 0", m.in_ready); end
      if (m.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", m.busy); end
    end
    step();
    m.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    @(negedge clk);
    checks += 2;
    if (m.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", m.in_ready); end
    if (m.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", m.busy); end
    step();
    send_pair(8'd31, 8'd18);
    send_pair(8'd1, 8'd1);
    send_pair(8'd255, 8'd255);
    send_pair(8'd0, 8'd7);
    @(negedge clk);
    checks += 2;
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_out_valid got %b want 0", m.out_valid); end
    if (m.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_drain_in_ready got %b want 0", m.in_ready); end
    @(negedge clk);
    checks += 3;
    if (m.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b want 1", m.out_valid); end
    if (m.result !== 24'd65584) begin errors++; $display("FAIL b2b_result got %0d want 65584", m.result); end
    if (m.ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", m.ovf); end
    release_result();
    @(negedge clk);
    checks += 2;
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release_out_valid got %b want 0", m.out_valid); end
    if (m.busy !== 1'b0) begin errors++; $display("FAIL b2b_release_busy got %b want 0", m.busy); end
    step();
  endtask

  task automatic test_gaps_stall();
    logic [7:0] pa [4] = '{8'd31, 8'd1, 8'd255, 8'd0};
    logic [7:0] pb [4] = '{8'd18, 8'd1, 8'd255, 8'd7};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_pair(pa[i], pb[i]);
      if (i < 3) begin
        @(negedge clk);
        checks++;
        if (m.in_ready !== 1'b1) begin errors++; $display("FAIL gap_in_ready pair %0d got %b want 1", i, m.in_ready); end
        step();
        step();
      end
    end
    wait_done("gap");
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (m.result !== 24'd65584) begin errors++; $display("FAIL stall_result cyc %0d got %0d want 65584", i, m.result); end
      if (m.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc %0d got %b want 1", i, m.out_valid); end
      @(negedge clk);
    end
    release_result();
    @(negedge clk);
    checks++;
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_out_valid got %b want 0", m.out_valid); end
    step();
  endtask

  task automatic test_overflow();
    int n = 0;
    w.start = 1'b1;
    step();
    w.start = 1'b0;
    w.in_valid = 1'b1; w.a = 8'd255; w.b = 8'd255;
    @(negedge clk);
    checks++;
    if (w.in_ready !== 1'b1) begin errors++; $display("FAIL ovf_in_ready got %b want 1", w.in_ready); end
    step();
    step();
    w.in_valid = 1'b0;
    @(negedge clk);
    while (!w.out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks += 3;
    if (w.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_out_valid got %b want 1", w.out_valid); end
    if (w.result !== 16'd64514) begin errors++; $display("FAIL ovf_result got %0d want 64514", w.result); end
    if (w.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", w.ovf); end
    w.out_ready = 1'b1;
    step();
    w.out_ready = 1'b0;
  endtask

  task automatic run_std_op();
    pulse_start();
    send_pair(8'd31, 8'd18);
    send_pair(8'd1, 8'd1);
    send_pair(8'd255, 8'd255);
    send_pair(8'd0, 8'd7);
    wait_done("std");
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_pair(8'd200, 8'd200);
    send_pair(8'd100, 8'd100);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (m.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", m.busy); end
    if (m.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", m.in_ready); end
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", m.out_valid); end
    if (m.result !== 24'd0) begin errors++; $display("FAIL midrst_result got %0d want 0", m.result); end
    step();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (m.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b want 0", m.out_valid); end
    end
    step();
    run_std_op();
    checks++;
    if (m.result !== 24'd65584) begin errors++; $display("FAIL midrst_new_result got %0d want 65584", m.result); end
    release_result();
    step();
  endtask

  task automatic test_restart();
    run_std_op();
    m.out_ready = 1'b1;
    m.start = 1'b1;
    step();
    m.out_ready = 1'b0;
    m.start = 1'b0;
    @(negedge clk);
    checks += 4;
    if (m.in_ready !== 1'b1) begin errors++; $display("FAIL restart_in_ready got %b want 1", m.in_ready); end
    if (m.busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", m.busy); end
    if (m.out_valid !== 1'b0) begin errors++; $display("FAIL restart_out_valid got %b want 0", m.out_valid); end
    if (m.result !== 24'd0) begin errors++; $display("FAIL restart_acc_clear got %0d want 0", m.result); end
    step();
    repeat (4) send_pair(8'd2, 8'd3);
    wait_done("restart");
    checks += 2;
    if (m.result !== 24'd24) begin errors++; $display("FAIL restart_result got %0d want 24", m.result); end
    if (m.ovf !== 1'b0) begin errors++; $display("FAIL restart_ovf got %b want 0", m.ovf); end
    release_result();
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps_stall();
    test_overflow();
    test_reset_mid();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
